multi_blink_timer: RTL and testbench
====================================

Name: multi_blink_timer

Overview:
Multi-channel programmable blink timer for the blinking-LED core. A shared, enable-gated prescaler generates a 1 ms tick. N_CH independent channels count ticks against a per-channel period register and toggle their LED output on each expiry, which gives a 50% duty blink with a half-period of per[i] ms. The block sits between the bus-side register interface (write port) and the board LED pins.

Parameters:
CLK_PER_TICK, 100_000, clk cycles per tick (100 MHz -> 1 ms); must be >= 2.
N_CH, 4, number of LED channels; must be >= 1.
CNT_W, 16, width of the period register and channel counter (max half-period 65535 ms).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  global run enable for the prescaler
wr_en  in  1  period write strobe, single cycle
wr_ch  in  max(1,$clog2(N_CH))  channel index for the write
wr_data  in  CNT_W  new half-period in ticks; 0 disables the channel
tic  out  1  registered one-cycle tick pulse
led  out  N_CH  registered LED drive, one bit per channel
expire  out  N_CH  registered one-cycle pulse per channel on each toggle

Behaviour:
- Reset: synchronous and active-high, sampled on the clk rising edge. After the edge where rst=1, the following are all 0: prescaler, tic, every per[i], every cnt[i], led, expire. rst has priority over all other inputs. Asserting rst mid-count clears state at the next edge. There is no partial state.
- Prescaler: $clog2(CLK_PER_TICK)-bit counter, 0..CLK_PER_TICK-1.
  - While en=1: increments each cycle and wraps to 0 after CLK_PER_TICK-1. On the wrap edge, tic<=1. On every other edge, tic<=0.
  - While en=0: prescaler<=0 and tic<=0. The channels hold their state, because no tic arrives.
  - Result: with en high continuously, tic is high exactly 1 of every CLK_PER_TICK cycles. The first tic is high during the CLK_PER_TICK-th cycle after en rises.
- Channel i, evaluated each edge in priority order:
  1. Write hit (wr_en=1, wr_ch==i): per[i]<=wr_data, cnt[i]<=0, led[i]<=0, expire[i]<=0. The write wins over a simultaneous tic for that channel. Other channels are unaffected.
  2. per[i]==0: channel disabled. cnt[i]<=0, led[i]<=0, expire[i]<=0.
  3. tic=1 and cnt[i]==per[i]-1: cnt[i]<=0, led[i]<=~led[i], expire[i]<=1.
  4. tic=1 otherwise: cnt[i]<=cnt[i]+1, expire[i]<=0.
  5. No tic: hold cnt[i] and led[i], expire[i]<=0.
- Latency: the led toggle and the expire pulse occur on the edge where tic is sampled high. That is the per[i]-th tic after the write, or after the previous expiry.
- Period 1: the LED toggles every tic. Maximum period 2^CNT_W-1. cnt never exceeds per-1. The per-1 comparison is computed in CNT_W bits and is only evaluated when per != 0, so it never underflows.
- Out-of-range write (wr_ch >= N_CH, non-power-of-2 N_CH): ignored, no state changes.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

Decomposition:
- Package blink_pkg: default constants CLK_PER_TICK_100MHZ=100_000 and CNT_W_DEF=16, plus typedef period_t = logic [CNT_W_DEF-1:0].
- Sub-module tick_prescaler: parameter CLK_PER_TICK; ports clk, rst, en, tic. It is the generalised enable-gated tick counter and is instantiated once.
- The channel logic is a generate loop in multi_blink_timer. No further sub-modules.

Test Plan:
(All with CLK_PER_TICK=10, N_CH=4, CNT_W=8.)
1. Reset then en=1 for 100 cycles -> tic high on cycles 10,20,...,100 only. led=0 and expire=0 throughout, because all per=0.
2. Write ch0 per=3, en=1 -> led[0] toggles 0->1 on the 3rd tic (cycle 30), 1->0 on the 6th tic (cycle 60). expire[0] pulses for one cycle on each toggle.
3. Write ch1 per=1 and ch2 per=2 -> led[1] toggles on every tic, led[2] on every 2nd tic. Channel 3 stays 0.
4. Write ch0 per=5 on the same cycle as a tic, while cnt[0]=2 -> cnt[0]=0 and led[0]=0 after the edge. The next toggle comes 5 tics later.
5. Drop en for 37 cycles mid-count, then restore it -> no tic while en=0. The prescaler restarts, the next tic arrives 10 cycles after en rises, and the channel counts resume from their held values.
6. Assert rst for 1 cycle while led[1]=1 and per[1]=1 -> all outputs are 0 on the next edge. per[1]=0, so led[1] stays 0 afterwards. A write to wr_ch=3 with N_CH=3 changes nothing.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared defaults for the blinking-LED core: 100 MHz -> 1 ms tick,
// 16-bit half-period registers.
package blink_pkg;

  localparam int CLK_PER_TICK_100MHZ = 100_000;
  localparam int CNT_W_DEF           = 16;

  typedef logic [CNT_W_DEF-1:0] period_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated tick generator: one registered tic pulse every CLK_PER_TICK
// enabled cycles. Dropping en restarts the count from zero.
module tick_prescaler import blink_pkg::*; #(
  parameter int CLK_PER_TICK = CLK_PER_TICK_100MHZ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tic
);

  localparam int          CW   = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_TICK - 1);

  logic [CW-1:0] pcnt;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pcnt <= '0;
      tic  <= 1'b0;
    end else if (pcnt == LAST) begin
      pcnt <= '0;
      tic  <= 1'b1;
    end else begin
      pcnt <= pcnt + CW'(1);
      tic  <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_blink_timer.sv
// N_CH independent LED blink channels sharing one ms prescaler; each channel
// toggles its LED every per[i] ticks (per[i] = 0 parks the channel low).
module multi_blink_timer import blink_pkg::*; #(
  parameter int CLK_PER_TICK = CLK_PER_TICK_100MHZ,
  parameter int N_CH         = 4,
  parameter int CNT_W        = CNT_W_DEF,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tic,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  expire
);

  tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tic (tic)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] per_q, cnt_q;
    logic             led_q, exp_q;
    logic             hit, last;

    // Indices >= N_CH never match, so out-of-range writes fall through.
    assign hit  = wr_en && (wr_ch == CH_W'(i));
    // Only consulted when per_q != 0, so the subtraction cannot wrap.
    assign last = (cnt_q == per_q - CNT_W'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        per_q <= '0;
        cnt_q <= '0;
        led_q <= 1'b0;
        exp_q <= 1'b0;
      end else if (hit) begin
        per_q <= wr_data;
        cnt_q <= '0;
        led_q <= 1'b0;
        exp_q <= 1'b0;
      end else if (per_q == '0) begin
        cnt_q <= '0;
        led_q <= 1'b0;
        exp_q <= 1'b0;
      end else if (tic && last) begin
        cnt_q <= '0;
        led_q <= ~led_q;
        exp_q <= 1'b1;
      end else if (tic) begin
        cnt_q <= cnt_q + CNT_W'(1);
        exp_q <= 1'b0;
      end else begin
        exp_q <= 1'b0;
      end
    end

    assign led[i]    = led_q;
    assign expire[i] = exp_q;
  end

endmodule

// File: tb/tb_multi_blink_timer.sv
// Scoreboarded bench: a tick/toggle-count reference model pushes expected
// outputs each edge; a negedge monitor pops and compares both DUT variants.
module tb_multi_blink_timer;

  localparam int CPT = 10;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_ch = '0;
  logic [CW-1:0] wr_data = '0;
  logic          tic, tic3;
  logic [NCH-1:0] led, expire;
  logic [2:0]    led3, expire3;

  always #5 clk = ~clk;

  multi_blink_timer #(.CLK_PER_TICK(CPT), .N_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .tic(tic), .led(led), .expire(expire)
  );

  // Three-channel variant sharing the same inputs: ch3 writes must be no-ops.
  multi_blink_timer #(.CLK_PER_TICK(CPT), .N_CH(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .tic(tic3), .led(led3), .expire(expire3)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic           tic;
    logic [NCH-1:0] led;
    logic [NCH-1:0] expire;
  } exp_t;

  exp_t q[$];
  int   run_m;               // consecutive enabled cycles
  logic tic_m = 1'b0;
  int   per_m [NCH];
  int   nt_m  [NCH];         // tics seen since write / last expiry
  int   flips_m [NCH];       // toggle count; led is its parity
  logic [NCH-1:0] exp_m;
  int   model_exp_total = 0;

  always @(posedge clk) begin
    exp_t e;
    logic tic_s;
    if (rst) begin
      run_m = 0;
      tic_m = 1'b0;
      exp_m = '0;
      for (int i = 0; i < NCH; i++) begin per_m[i] = 0; nt_m[i] = 0; flips_m[i] = 0; end
    end else begin
      tic_s = tic_m;
      if (en) begin run_m++; tic_m = (run_m % CPT) == 0; end
      else begin run_m = 0; tic_m = 1'b0; end
      for (int i = 0; i < NCH; i++) begin
        exp_m[i] = 1'b0;
        if (wr_en && int'(wr_ch) == i) begin
          per_m[i] = int'(wr_data); nt_m[i] = 0; flips_m[i] = 0;
        end else if (per_m[i] == 0) begin
          nt_m[i] = 0; flips_m[i] = 0;
        end else if (tic_s) begin
          nt_m[i]++;
          if (nt_m[i] == per_m[i]) begin
            nt_m[i] = 0; flips_m[i]++; exp_m[i] = 1'b1; model_exp_total++;
          end
        end
      end
    end
    e.tic = tic_m;
    e.expire = exp_m;
    for (int i = 0; i < NCH; i++) e.led[i] = flips_m[i][0];
    q.push_back(e);
  end

  // ---------------- monitor ----------------
  int dut_tics = 0;
  int dut_exp_total = 0;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tic", 32'(tic), 32'(e.tic));
      chk("led", 32'(led), 32'(e.led));
      chk("expire", 32'(expire), 32'(e.expire));
      chk("led_n3", 32'(led3), 32'(e.led[2:0]));
      chk("expire_n3", 32'(expire3), 32'(e.expire[2:0]));
      if (tic === 1'b1) dut_tics++;
      for (int i = 0; i < NCH; i++) if (expire[i] === 1'b1) dut_exp_total++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_data = CW'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int t0, k;
    cyc(3);
    rst = 1'b0;

    // 1: ten tics in 100 enabled cycles, all channels idle
    t0 = dut_tics;
    en = 1'b1;
    cyc(100);
    #1 chk("tic_count_100", 32'(dut_tics - t0), 32'd10);

    // 2: ch0 half-period 3
    wr(0, 3);
    cyc(70);

    // 3: ch1 every tic, ch2 every other tic
    wr(1, 1);
    wr(2, 2);
    cyc(60);

    // 4: rewrite ch0 exactly when a tic is due and cnt0 == 2
    k = 0;
    while (!(tic_m && nt_m[0] == 2) && k < 300) begin cyc(1); k++; end
    chk("align_write_ch0", 32'(k < 300), 32'd1);
    wr(0, 5);
    cyc(70);

    // 5: pause the prescaler mid-count
    cyc(4);
    en = 1'b0;
    cyc(37);
    en = 1'b1;
    cyc(80);

    // 6: reset while led1 is high, then out-of-range write for the 3-ch variant
    k = 0;
    while (!flips_m[1][0] && k < 300) begin cyc(1); k++; end
    chk("led1_high_before_rst", 32'(k < 300), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(30);
    wr(0, 1);
    wr(3, 2);
    cyc(60);

    // randomized phase
    for (int c = 0; c < 2500; c++) begin
      en    = ($urandom_range(0, 19) != 0);
      rst   = ($urandom_range(0, 399) == 0);
      wr_en = ($urandom_range(0, 24) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 7) == 0) ? CW'(0) : CW'($urandom_range(1, 4));
      if ($urandom_range(0, 99) == 0) wr_data = CW'($urandom_range(0, 255));
      cyc(1);
    end
    rst = 1'b0; wr_en = 1'b0; en = 1'b1;
    cyc(3);
    #1;
    chk("expire_total", 32'(dut_exp_total), 32'(model_exp_total));
    chk("queue_drained", 32'(q.size() <= 1), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
